// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT mode core: FSM states, default
// parameters and the bit-reversed twiddle ROM for Q = 8380417.
package ntt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    SCALE,
    UNLOAD
  } ntt_state_e;

  localparam int NTT_N     = 256;
  localparam int NTT_W     = 23;
  localparam int NTT_Q     = 8380417;
  localparam int NTT_N_INV = 8347681;

  // 1753 is a primitive 512th root of unity mod 8380417
  localparam int ZETA_ROOT  = 1753;
  localparam int ZETA_DEPTH = 256;

  typedef logic [ZETA_DEPTH-1:0][NTT_W-1:0] zeta_rom_t;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

  // zeta[k] = root^bitrev8(k) mod Q; entry 0 is never addressed and held at 0
  function automatic zeta_rom_t gen_zetas();
    zeta_rom_t rom;
    longint unsigned pw;
    rom = '0;
    pw  = 64'd1;
    for (int i = 0; i < ZETA_DEPTH; i++) begin
      rom[bitrev8(8'(i))] = NTT_W'(pw);
      pw = (pw * 64'(ZETA_ROOT)) % 64'(NTT_Q);
    end
    rom[0] = '0;
    return rom;
  endfunction

  localparam zeta_rom_t ZETAS = gen_zetas();

endpackage

// File: rtl/ntt_mode_core_if.sv
// Streaming control/data bundle between the NTT core and its host.
interface ntt_mode_core_if
  import ntt_pkg::*;
#(
  parameter int W = NTT_W
);

  logic         start;
  logic         inverse;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         busy;
  logic         done;

  modport master (
    output start, inverse, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  start, inverse, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );

endinterface

// File: rtl/ntt_modmul.sv
// Combinational modular multiplier: p = a*b mod Q with a full 2W-bit product.
module ntt_modmul #(
  parameter int W = 23,
  parameter int Q = 8380417
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  localparam logic [2*W-1:0] Q_WIDE = (2*W)'(Q);

  logic [2*W-1:0] prod;

  always_comb begin
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p    = W'(prod % Q_WIDE);
  end

endmodule

// File: rtl/ntt_mode_core.sv
// In-place radix-2 NTT/INTT core: streams N coefficients in, runs one butterfly
// per cycle, optionally scales by N^-1, then streams the result out.
module ntt_mode_core
  import ntt_pkg::*;
#(
  parameter int N     = NTT_N,
  parameter int W     = NTT_W,
  parameter int Q     = NTT_Q,
  parameter int N_INV = NTT_N_INV
) (
  input  logic            clk,
  input  logic            rst,
  ntt_mode_core_if.slave  bus
);

  localparam int L  = $clog2(N);
  localparam int SW = $clog2(L);

  typedef logic [L-1:0]  idx_t;
  typedef logic [L-2:0]  bfly_t;
  typedef logic [SW-1:0] stage_t;

  localparam logic [W-1:0] Q_W     = W'(Q);
  localparam logic [W:0]   Q_X     = (W+1)'(Q);
  localparam logic [W-1:0] N_INV_W = W'(N_INV);

  ntt_state_e   state_q, state_d;
  logic         inv_q;
  idx_t         idx_q;
  bfly_t        bfly_q;
  stage_t       stage_q;
  logic         done_q;
  logic [W-1:0] mem [N];

  logic         idx_last, bfly_last, stage_last;
  stage_t       log_len;
  idx_t         bfly_ext, len_bit, len_mask, j_lo, j_hi, k_sel;
  logic [7:0]   zeta_addr;
  logic [W-1:0] zeta, a_val, b_val, diff, in_reduced;
  logic [W-1:0] mul_a, mul_b, prod, bf_lo, bf_hi;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= Q_X) s = s - Q_X;
    return W'(s);
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + Q_X;
    return W'(d);
  endfunction

  assign idx_last   = &idx_q;
  assign bfly_last  = &bfly_q;
  assign stage_last = (stage_q == stage_t'(L - 1));

  // Butterfly b of a stage pairs j_lo with j_lo+len: b's low log_len bits are the
  // offset inside a block, the rest is the block number (spread by 2*len).
  always_comb begin
    log_len   = inv_q ? stage_q : stage_t'(L - 1) - stage_q;
    bfly_ext  = {1'b0, bfly_q};
    len_bit   = idx_t'(1) << log_len;
    len_mask  = len_bit - idx_t'(1);
    j_lo      = ((bfly_ext & ~len_mask) << 1) | (bfly_ext & len_mask);
    j_hi      = j_lo | len_bit;
    if (inv_q) begin
      k_sel = ({L{1'b1}} >> stage_q) - (bfly_ext >> stage_q);
    end else begin
      k_sel = (idx_t'(1) << stage_q) | (bfly_ext >> log_len);
    end
    zeta_addr = 8'(k_sel);
    zeta      = W'(ZETAS[zeta_addr]);
  end

  always_comb begin
    a_val      = mem[j_lo];
    b_val      = mem[j_hi];
    diff       = mod_sub(a_val, b_val);
    in_reduced = (bus.in_data >= Q_W) ? bus.in_data - Q_W : bus.in_data;
    mul_a      = N_INV_W;
    mul_b      = mem[idx_q];
    if (state_q == COMPUTE) begin
      mul_a = inv_q ? (Q_W - zeta) : zeta;
      mul_b = inv_q ? diff : b_val;
    end
  end

  // The single multiplier serves the butterfly twiddle and the N^-1 scaling
  ntt_modmul #(
    .W(W),
    .Q(Q)
  ) u_modmul (
    .a(mul_a),
    .b(mul_b),
    .p(prod)
  );

  always_comb begin
    if (inv_q) begin
      bf_lo = mod_add(a_val, b_val);
      bf_hi = prod;
    end else begin
      bf_lo = mod_add(a_val, prod);
      bf_hi = mod_sub(a_val, prod);
    end
  end

  always_ff @(posedge clk) begin
    case (state_q)
      LOAD: begin
        if (bus.in_valid) mem[idx_q] <= in_reduced;
      end
      COMPUTE: begin
        mem[j_lo] <= bf_lo;
        mem[j_hi] <= bf_hi;
      end
      SCALE: begin
        mem[idx_q] <= prod;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD:    if (bus.in_valid && idx_last) state_d = COMPUTE;
      COMPUTE: if (bfly_last && stage_last) state_d = inv_q ? SCALE : UNLOAD;
      SCALE:   if (idx_last) state_d = UNLOAD;
      UNLOAD:  if (bus.out_ready && idx_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Index counters wrap at N, so each phase naturally hands over at index 0
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q   <= 1'b0;
      idx_q   <= '0;
      bfly_q  <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            inv_q   <= bus.inverse;
            idx_q   <= '0;
            bfly_q  <= '0;
            stage_q <= '0;
          end
        end
        LOAD: begin
          if (bus.in_valid) idx_q <= idx_q + idx_t'(1);
        end
        COMPUTE: begin
          bfly_q <= bfly_q + bfly_t'(1);
          if (bfly_last) stage_q <= stage_last ? '0 : stage_q + stage_t'(1);
        end
        SCALE: begin
          idx_q <= idx_q + idx_t'(1);
        end
        UNLOAD: begin
          if (bus.out_ready) begin
            idx_q  <= idx_q + idx_t'(1);
            done_q <= idx_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == UNLOAD);
  assign bus.out_data  = (state_q == UNLOAD) ? mem[idx_q] : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ntt_mode_core.sv
// Self-checking bench for ntt_mode_core: vector table of known transforms,
// round trip, backpressure, spurious start and abort sequences.
module tb_ntt_mode_core;

  localparam int N          = 256;
  localparam int W          = 23;
  localparam int QI         = 8380417;
  localparam int TXN_BUDGET = 8000;

  typedef struct {
    logic         inv;
    logic         imp_in;
    logic [W-1:0] in_val;
    logic         imp_out;
    logic [W-1:0] out_val;
    int           stall_pct;
    bit           spurious;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ntt_mode_core_if #(.W(W)) bus ();

  ntt_mode_core dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] din  [N];
  logic [W-1:0] expv [N];
  logic [W-1:0] got  [N];
  logic [W-1:0] orig [N];
  logic [W-1:0] exp_q [$];
  vec_t vecs [8];

  task automatic checkOutput(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One full transaction from start to done; expected words are queued as
  // the matching inputs are driven and popped as outputs are accepted.
  task automatic applyStimulus(input logic inv, input int stall_pct, input bit spurious,
                               input bit compare_on, input int exp_busy_cycles);
    int in_cnt, out_cnt, cycles, busy_cycles, done_early;
    bit held;
    logic [W-1:0] held_data, e;
    in_cnt = 0; out_cnt = 0; cycles = 0; busy_cycles = 0; done_early = 0;
    held = 1'b0; held_data = '0;
    exp_q.delete();
    bus.start   = 1'b1;
    bus.inverse = inv;
    while (out_cnt < N && cycles < TXN_BUDGET) begin
      @(negedge clk);
      cycles++;
      if (bus.done) done_early++;
      if (bus.busy && !bus.in_ready && !bus.out_valid) busy_cycles++;
      if (held) checkOutput("stall_stable", bus.out_data, held_data);
      held = 1'b0;
      if (bus.in_ready && in_cnt < N && int'($urandom_range(99)) >= stall_pct) begin
        bus.in_valid = 1'b1;
        bus.in_data  = din[in_cnt];
        exp_q.push_back(expv[in_cnt]);
        in_cnt++;
      end else if (bus.in_ready) begin
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
      end else begin
        bus.in_valid = 1'($urandom_range(1));
        bus.in_data  = W'($urandom);
      end
      if (bus.out_valid) begin
        if (int'($urandom_range(99)) >= stall_pct) begin
          bus.out_ready = 1'b1;
          got[out_cnt]  = bus.out_data;
          if (compare_on) checkOutput("scoreboard_level", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (compare_on) checkOutput($sformatf("out[%0d]", out_cnt), bus.out_data, e);
          end
          out_cnt++;
        end else begin
          bus.out_ready = 1'b0;
          held      = 1'b1;
          held_data = bus.out_data;
        end
      end else begin
        bus.out_ready = 1'($urandom_range(1));
      end
      bus.start   = spurious && (bus.in_ready || (bus.out_valid && out_cnt < N))
                    && ($urandom_range(3) == 0);
      bus.inverse = ~inv;
    end
    checkOutput("txn_outputs", out_cnt, N);
    @(negedge clk);
    checkOutput("done_pulse", bus.done, 1);
    checkOutput("idle_after_done", bus.busy, 0);
    checkOutput("done_early", done_early, 0);
    checkOutput("compute_scale_cycles", busy_cycles, exp_busy_cycles);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic runVector(input vec_t v);
    for (int i = 0; i < N; i++) begin
      din[i]  = (v.imp_in  && i != 0) ? '0 : v.in_val;
      expv[i] = (v.imp_out && i != 0) ? '0 : v.out_val;
    end
    applyStimulus(v.inv, v.stall_pct, v.spurious, 1'b1, v.inv ? 1280 : 1024);
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // fields: inv, impulse-in, in value, impulse-out, out value, stall %, spurious start
    vecs[0] = '{1'b0, 1'b1, W'(1),      1'b0, W'(1),      0,  1'b0};
    vecs[1] = '{1'b1, 1'b0, W'(1),      1'b1, W'(1),      0,  1'b0};
    vecs[2] = '{1'b0, 1'b1, W'(QI - 1), 1'b0, W'(QI - 1), 0,  1'b0};
    vecs[3] = '{1'b1, 1'b0, W'(QI - 1), 1'b1, W'(QI - 1), 0,  1'b0};
    vecs[4] = '{1'b0, 1'b1, W'(QI + 5), 1'b0, W'(5),      0,  1'b0};
    vecs[5] = '{1'b0, 1'b1, W'(1),      1'b0, W'(1),      50, 1'b0};
    vecs[6] = '{1'b0, 1'b1, W'(1),      1'b0, W'(1),      0,  1'b1};
    vecs[7] = '{1'b1, 1'b0, W'(7),      1'b1, W'(7),      30, 1'b1};

    rst = 1'b1;
    bus.start = 1'b0; bus.inverse = 1'b0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready",  bus.in_ready,  0);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_out_data",  bus.out_data,  0);
    checkOutput("reset_busy",      bus.busy,      0);
    checkOutput("reset_done",      bus.done,      0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      $display("[TB] vector %0d", v);
      runVector(vecs[v]);
    end

    $display("[TB] round trip");
    for (int i = 0; i < N; i++) begin
      din[i]  = W'($urandom_range(QI - 1));
      orig[i] = din[i];
      expv[i] = '0;
    end
    din[3]  = W'(QI + 5);
    orig[3] = W'(5);
    applyStimulus(1'b0, 20, 1'b0, 1'b0, 1024);
    din  = got;
    expv = orig;
    applyStimulus(1'b1, 20, 1'b0, 1'b1, 1280);

    $display("[TB] abort during compute");
    for (int i = 0; i < N; i++) din[i] = (i == 0) ? W'(1) : '0;
    bus.start = 1'b1; bus.inverse = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = din[i];
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (499) @(negedge clk);
    checkOutput("abort_in_compute", bus.busy && !bus.in_ready && !bus.out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy",      bus.busy,      0);
    checkOutput("abort_out_valid", bus.out_valid, 0);
    checkOutput("abort_in_ready",  bus.in_ready,  0);
    checkOutput("abort_done",      bus.done,      0);
    rst = 1'b0;
    @(negedge clk);
    runVector(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_mode_core.md
NTT_MODE_CORE -- requirements
Module: ntt_mode_core

Interface
REQ-001 SHALL have parameter N, default 256, transform length (power of two, 8..256).
REQ-002 SHALL have parameter W, default 23, coefficient width (unsigned, Q < 2^W).
REQ-003 SHALL have parameter Q, default 8380417, prime modulus.
REQ-004 SHALL have parameter N_INV, default 8347681, N^-1 mod Q.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 start  in  1  begin a transaction; sampled only in IDLE.
REQ-008 inverse  in  1  0 = forward NTT, 1 = inverse NTT; sampled with start.
REQ-009 in_valid  in  1  input coefficient present.
REQ-010 in_data  in  W  input coefficient, natural order index 0..N-1.
REQ-011 in_ready  out  1  core accepts in_data.
REQ-012 out_valid  out  1  output coefficient present.
REQ-013 out_data  out  W  output coefficient, index 0..N-1.
REQ-014 out_ready  in  1  sink accepts out_data.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse at the end of a transaction.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, COMPUTE, SCALE, UNLOAD.
REQ-018 IDLE: start=1 -> LOAD, latch inverse; no other transition.
REQ-019 LOAD: in_ready=1; each in_valid&in_ready cycle writes in_data to the next index; after index N-1 -> COMPUTE.
REQ-020 LOAD: any in_data >= Q SHALL be reduced by one subtraction of Q (inputs < 2Q required).
REQ-021 COMPUTE: exactly one butterfly per cycle, no bubbles, (N/2)*log2(N) cycles (1024 at N=256).
REQ-022 Forward: len = N/2 down to 1; k pre-incremented from 0 per block; t = zeta[k]*w[j+len] mod Q; w[j+len] = w[j]-t mod Q; w[j] = w[j]+t mod Q.
REQ-023 Inverse: len = 1 up to N/2; k pre-decremented from N per block; t = w[j]; w[j] = t+w[j+len] mod Q; w[j+len] = (Q-zeta[k])*(t-w[j+len]) mod Q.
REQ-024 All stored coefficients SHALL stay in [0, Q-1]; modular add/sub by single conditional correction; products are 2W bits, reduced fully.
REQ-025 COMPUTE end: forward -> UNLOAD; inverse -> SCALE.
REQ-026 SCALE: one coefficient per cycle, w[i] = w[i]*N_INV mod Q, N cycles, then -> UNLOAD.
REQ-027 UNLOAD: out_valid=1, out_data = w[idx]; idx advances only on out_valid&out_ready; out_data stable while out_ready=0.
REQ-028 Final handshake (idx N-1): next cycle done=1 and state IDLE.
REQ-029 start outside IDLE SHALL be ignored; in_valid outside LOAD ignored; inverse changes after start ignored.
REQ-030 start and done in the same cycle: not possible (done coincides with IDLE entry); start in that IDLE cycle SHALL be accepted.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE from any state, aborting the transaction.
REQ-032 Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, all counters 0.
REQ-033 Coefficient storage SHALL need no reset; contents after abort are don't-care.

Structure
REQ-034 Package ntt_pkg SHALL hold state enum, default N/W/Q/N_INV and the bit-reversed zeta ROM (256 entries, Q=8380417, zeta[0]=0, zeta[1]=4808194).
REQ-035 One sub-module ntt_modmul (a*b mod Q, combinational, parameters W, Q) SHALL be shared by butterfly and SCALE.
REQ-036 Coefficient storage SHALL be a register array of N x W; no signed types.

Verification
REQ-037 Forward impulse: load [1,0,...,0], inverse=0 -> all 256 outputs = 1; done 1 cycle after last output.
REQ-038 Inverse of ones: load 256 x 1, inverse=1 -> output [1,0,...,0]; COMPUTE 1024 + SCALE 256 cycles counted exactly.
REQ-039 Round trip: random vector in [0,Q-1] forward then inverse -> bit-exact input; also input Q+5 at index 3 treated as 5.
REQ-040 Backpressure: out_ready toggled random 50% -> same output sequence, out_data stable while stalled, no duplicates/drops.
REQ-041 Abort: rst asserted at COMPUTE cycle 500 -> IDLE, busy=0, out_valid=0 next cycle; following forward impulse passes.
REQ-042 Spurious start: start pulsed during LOAD and UNLOAD -> no state change, results identical to REQ-037.
